// File: rtl/vec_mem_sequencer_pkg.sv
// Shared definitions for the vector memory sequencer: default widths,
// derived lane geometry and the access FSM state type.
package vec_mem_pkg;

   localparam int VEC_WIDTH   = 128;
   localparam int WORD_WIDTH  = 32;
   localparam int ADDR_WIDTH  = 32;

   localparam int LANES       = VEC_WIDTH / WORD_WIDTH;
   localparam int BYTE_STRIDE = WORD_WIDTH / 8;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      DONE   = 2'd2
   } stateT;

   // Lane counter width; a single-lane configuration still needs one bit.
   function automatic int cntWidth(input int lanes);
      return (lanes > 1) ? $clog2(lanes) : 1;
   endfunction

endpackage

// File: rtl/vec_mem_sequencer_if.sv
// Word-wide data-memory port between the vector sequencer (master) and
// the data memory (slave).
interface vec_mem_sequencer_if #(
   parameter int ADDR_WIDTH = vec_mem_pkg::ADDR_WIDTH,
   parameter int WORD_WIDTH = vec_mem_pkg::WORD_WIDTH
) ();

   logic                  mem_req;
   logic                  mem_we;
   logic [ADDR_WIDTH-1:0] mem_addr;
   logic [WORD_WIDTH-1:0] mem_wdata;
   logic [WORD_WIDTH-1:0] mem_rdata;
   logic                  mem_ack;

   modport master (
      output mem_req, mem_we, mem_addr, mem_wdata,
      input  mem_rdata, mem_ack
   );

   modport slave (
      input  mem_req, mem_we, mem_addr, mem_wdata,
      output mem_rdata, mem_ack
   );

endinterface

// File: rtl/vec_mem_sequencer.sv
// Memory-stage vector load/store unit: splits one vector access into
// LANES word transactions and stalls the pipeline through Busy until the
// last word has been acknowledged.
module vec_mem_sequencer #(
   parameter int VEC_WIDTH  = vec_mem_pkg::VEC_WIDTH,
   parameter int WORD_WIDTH = vec_mem_pkg::WORD_WIDTH,
   parameter int ADDR_WIDTH = vec_mem_pkg::ADDR_WIDTH
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  start,
   input  logic                  we,
   input  logic [ADDR_WIDTH-1:0] base_addr,
   input  logic [VEC_WIDTH-1:0]  wdata_vec,
   vec_mem_sequencer_if.master   mem,
   output logic                  Busy,
   output logic                  done,
   output logic [VEC_WIDTH-1:0]  rdata_vec
);

   import vec_mem_pkg::*;

   localparam int LANES       = VEC_WIDTH / WORD_WIDTH;
   localparam int BYTE_STRIDE = WORD_WIDTH / 8;
   localparam int CNT_WIDTH   = cntWidth(LANES);
   localparam int ALIGN_BITS  = $clog2(BYTE_STRIDE);

   localparam logic [CNT_WIDTH-1:0]  LAST_LANE  = CNT_WIDTH'(LANES - 1);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~ADDR_WIDTH'(BYTE_STRIDE - 1);

   stateT                 state;
   stateT                 nextState;

   logic                  weLat;
   logic [ADDR_WIDTH-1:0] baseLat;
   logic [VEC_WIDTH-1:0]  wdataLat;
   logic [CNT_WIDTH-1:0]  laneCnt;
   logic [VEC_WIDTH-1:0]  rdataReg;

   logic                  capture;
   logic                  ackTaken;
   logic                  lastLane;
   logic [ADDR_WIDTH-1:0] laneAddr;
   logic [WORD_WIDTH-1:0] laneData;

   // An ack only counts while a request is outstanding; stray acks are dropped.
   assign capture  = (state == IDLE) && start;
   assign ackTaken = (state == ACCESS) && mem.mem_ack;
   assign lastLane = (laneCnt == LAST_LANE);

   // Lane address wraps silently at 2^ADDR_WIDTH; lane data is the latched slice.
   assign laneAddr = baseLat + (ADDR_WIDTH'(laneCnt) << ALIGN_BITS);
   assign laneData = wdataLat[int'(laneCnt) * WORD_WIDTH +: WORD_WIDTH];

   assign rdata_vec = rdataReg;

   // State register.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: sequential state is updated with <= so every flop samples the
      // pre-edge values; blocking = here would create order-dependent races.
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= nextState;
      end
   end

   // Next-state logic: start is only looked at in IDLE, so the instruction
   // still sitting in M during DONE cannot retrigger an access.
   always_comb begin
      nextState = state;
      case (state)
         IDLE:    if (start) nextState = ACCESS;
         ACCESS:  if (mem.mem_ack && lastLane) nextState = DONE;
         DONE:    nextState = IDLE;
         default: nextState = IDLE;
      endcase
   end

   // Outputs: memory port is quiet (all zero) outside ACCESS; Busy covers the
   // cycle start first appears so the hazard unit stalls immediately.
   always_comb begin
      // NOTE: every output gets a default before the case so no path leaves
      // a signal unassigned, which would otherwise infer a latch.
      mem.mem_req   = 1'b0;
      mem.mem_we    = 1'b0;
      mem.mem_addr  = '0;
      mem.mem_wdata = '0;
      Busy          = 1'b0;
      done          = 1'b0;
      case (state)
         IDLE: begin
            Busy = start;
         end
         ACCESS: begin
            mem.mem_req   = 1'b1;
            mem.mem_we    = weLat;
            mem.mem_addr  = laneAddr;
            mem.mem_wdata = laneData;
            Busy          = 1'b1;
         end
         DONE: begin
            done = 1'b1;
         end
         default: ;
      endcase
   end

   // Request capture and lane counter; start-side inputs are ignored once latched.
   always_ff @(posedge clk or negedge rst_n) begin
      // NOTE: the wide data registers are reset on purpose: a reset mid-access
      // must leave no stale store data or address behind to be resumed.
      if (!rst_n) begin
         weLat    <= 1'b0;
         baseLat  <= '0;
         wdataLat <= '0;
         laneCnt  <= '0;
      end else if (capture) begin
         weLat    <= we;
         baseLat  <= base_addr & ALIGN_MASK;
         wdataLat <= wdata_vec;
         laneCnt  <= '0;
      end else if (ackTaken && !lastLane) begin
         laneCnt  <= laneCnt + CNT_WIDTH'(1);
      end
   end

   // Load assembly: each acknowledged word lands in its lane; stores leave it alone.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rdataReg <= '0;
      end else if (ackTaken && !weLat) begin
         rdataReg[int'(laneCnt) * WORD_WIDTH +: WORD_WIDTH] <= mem.mem_rdata;
      end
   end

endmodule

// File: tb/tb_vec_mem_sequencer.sv
// Self-checking bench for vec_mem_sequencer: directed scenarios followed by
// randomized accesses, all compared against expectations computed from the
// lane/address/latency rules of the block.
`timescale 1ns/1ps
module tb_vec_mem_sequencer;

   import vec_mem_pkg::*;

   logic                  clk = 1'b0;
   logic                  rst_n;
   logic                  start;
   logic                  we;
   logic [ADDR_WIDTH-1:0] base_addr;
   logic [VEC_WIDTH-1:0]  wdata_vec;
   logic                  Busy;
   logic                  done;
   logic [VEC_WIDTH-1:0]  rdata_vec;

   vec_mem_sequencer_if memBus ();

   vec_mem_sequencer dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .start     (start),
      .we        (we),
      .base_addr (base_addr),
      .wdata_vec (wdata_vec),
      .mem       (memBus),
      .Busy      (Busy),
      .done      (done),
      .rdata_vec (rdata_vec)
   );

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   // Memory contents seen by loads; unwritten words return an address hash.
   logic [WORD_WIDTH-1:0] memory [logic [ADDR_WIDTH-1:0]];
   // Expected value of rdata_vec between accesses.
   logic [VEC_WIDTH-1:0]  expRdata;

   task automatic check(input string tag, input logic [VEC_WIDTH-1:0] obs,
                        input logic [VEC_WIDTH-1:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [WORD_WIDTH-1:0] memRead(input logic [ADDR_WIDTH-1:0] a);
      if (memory.exists(a)) return memory[a];
      return a ^ 32'hA5A5_5A5A;
   endfunction

   // Advance to just after the next rising edge.
   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   // Idle cycles with start low; optionally a stray ack with all-ones data.
   task automatic idle(input int n, input bit stray);
      for (int k = 0; k < n; k++) begin
         nextCycle();
         start             = 1'b0;
         memBus.mem_ack    = stray;
         memBus.mem_rdata  = stray ? 32'hFFFF_FFFF : 32'h0;
         #1;
         check($sformatf("idle_req_%0d", k),   memBus.mem_req, 0);
         check($sformatf("idle_busy_%0d", k),  Busy, 0);
         check($sformatf("idle_done_%0d", k),  done, 0);
         check($sformatf("idle_rdata_%0d", k), rdata_vec, expRdata);
      end
   endtask

   // One complete vector access. delay = wait cycles before each word's ack
   // (0 means ack tied high). start stays high through the DONE cycle.
   task automatic access(input bit isStore, input logic [ADDR_WIDTH-1:0] base,
                         input logic [VEC_WIDTH-1:0] wvec, input int delay);
      logic [ADDR_WIDTH-1:0] expAddr [LANES];
      logic [VEC_WIDTH-1:0]  loadVec;
      logic [ADDR_WIDTH-1:0] obsAddr  [$];
      logic [WORD_WIDTH-1:0] obsWdata [$];
      logic                  obsWe    [$];
      logic [ADDR_WIDTH-1:0] prevAddr;
      logic [WORD_WIDTH-1:0] prevWdata;
      logic                  prevWe;
      bit                    prevHold;
      bit                    ackNow;
      int                    waitCnt;
      int                    expDone;

      expDone = LANES * (delay + 1) + 1;
      for (int i = 0; i < LANES; i++) begin
         expAddr[i] = ADDR_WIDTH'(base - base % BYTE_STRIDE + i * BYTE_STRIDE);
         loadVec[i * WORD_WIDTH +: WORD_WIDTH] = memRead(expAddr[i]);
      end

      // Cycle 0: the instruction reaches M.
      nextCycle();
      start            = 1'b1;
      we               = isStore;
      base_addr        = base;
      wdata_vec        = wvec;
      memBus.mem_ack   = (delay == 0);
      memBus.mem_rdata = 32'hFFFF_FFFF;
      #1;
      check("busy_c0", Busy, 1);
      check("req_c0",  memBus.mem_req, 0);

      waitCnt  = 0;
      prevHold = 1'b0;
      prevAddr = '0;
      prevWdata = '0;
      prevWe   = 1'b0;
      for (int c = 1; c <= expDone; c++) begin
         nextCycle();
         // Start-side inputs wander after capture; they must have no effect.
         we        = 1'($urandom);
         base_addr = $urandom;
         wdata_vec = {$urandom, $urandom, $urandom, $urandom};
         ackNow    = 1'b0;
         if (memBus.mem_req) begin
            if (waitCnt == delay) begin
               ackNow  = 1'b1;
               waitCnt = 0;
            end else begin
               waitCnt++;
            end
         end
         memBus.mem_ack   = ackNow;
         memBus.mem_rdata = memRead(memBus.mem_addr);
         #1;
         check($sformatf("req_c%0d", c),  memBus.mem_req, c < expDone);
         check($sformatf("busy_c%0d", c), Busy, c < expDone);
         check($sformatf("done_c%0d", c), done, c == expDone);
         if (prevHold) begin
            check($sformatf("addr_stable_c%0d", c),  memBus.mem_addr,  prevAddr);
            check($sformatf("wdata_stable_c%0d", c), memBus.mem_wdata, prevWdata);
            check($sformatf("we_stable_c%0d", c),    memBus.mem_we,    prevWe);
         end
         if (memBus.mem_req && ackNow) begin
            obsAddr.push_back(memBus.mem_addr);
            obsWdata.push_back(memBus.mem_wdata);
            obsWe.push_back(memBus.mem_we);
         end
         prevHold  = memBus.mem_req && !ackNow;
         prevAddr  = memBus.mem_addr;
         prevWdata = memBus.mem_wdata;
         prevWe    = memBus.mem_we;
         if (c == expDone)
            check("rdata_at_done", rdata_vec, isStore ? expRdata : loadVec);
      end

      if (!isStore) expRdata = loadVec;

      check("lane_count", obsAddr.size(), LANES);
      for (int i = 0; i < obsAddr.size() && i < LANES; i++) begin
         check($sformatf("addr_lane%0d", i), obsAddr[i], expAddr[i]);
         check($sformatf("we_lane%0d", i),   obsWe[i],   isStore);
         if (isStore)
            check($sformatf("wdata_lane%0d", i), obsWdata[i],
                  wvec[i * WORD_WIDTH +: WORD_WIDTH]);
      end
   endtask

   // Absolute time bound so a broken handshake can never hang the run.
   initial begin
      #1_000_000;
      $display("FAIL timeout: simulation exceeded its time budget");
      $fatal(1, "timeout");
   end

   initial begin
      rst_n            = 1'b0;
      start            = 1'b0;
      we               = 1'b0;
      base_addr        = '0;
      wdata_vec        = '0;
      memBus.mem_ack   = 1'b0;
      memBus.mem_rdata = '0;
      expRdata         = '0;

      memory[32'h0000_0100] = 32'h1111_1111;
      memory[32'h0000_0104] = 32'h2222_2222;
      memory[32'h0000_0108] = 32'h3333_3333;
      memory[32'h0000_010C] = 32'h4444_4444;

      // Reset state.
      #12;
      check("rst_req",   memBus.mem_req,   0);
      check("rst_we",    memBus.mem_we,    0);
      check("rst_addr",  memBus.mem_addr,  0);
      check("rst_wdata", memBus.mem_wdata, 0);
      check("rst_busy",  Busy,             0);
      check("rst_done",  done,             0);
      check("rst_rdata", rdata_vec,        0);
      @(negedge clk);
      rst_n = 1'b1;
      idle(2, 1'b0);

      // Load, ack tied high, done at cycle 5.
      access(1'b0, 32'h0000_0100, '0, 0);
      check("load_vec", rdata_vec, 128'h44444444_33333333_22222222_11111111);
      idle(2, 1'b0);

      // Store with two wait cycles per word, done at cycle 13.
      access(1'b1, 32'h0000_0200, 128'hDEADBEEF_CAFEF00D_01234567_89ABCDEF, 2);
      idle(2, 1'b0);

      // Misaligned base that wraps past the top of the address space.
      access(1'b0, 32'hFFFF_FFFE, '0, 0);
      idle(1, 1'b0);

      // Back-to-back: start held through DONE straight into a second access.
      access(1'b0, 32'h0000_0100, '0, 0);
      access(1'b1, 32'h0000_0400, {$urandom, $urandom, $urandom, $urandom}, 1);
      idle(4, 1'b0);

      // Stray acks with all-ones data while idle.
      idle(3, 1'b1);

      // Reset after the second lane's ack.
      nextCycle();
      start            = 1'b1;
      we               = 1'b0;
      base_addr        = 32'h0000_0300;
      memBus.mem_ack   = 1'b1;
      memBus.mem_rdata = 32'h5A5A_5A5A;
      for (int c = 1; c <= 3; c++) begin
         nextCycle();
         memBus.mem_rdata = memRead(memBus.mem_addr);
      end
      #1;
      check("pre_rst_req", memBus.mem_req, 1);
      rst_n = 1'b0;
      start = 1'b0;
      #1;
      check("mid_rst_req",   memBus.mem_req,  0);
      check("mid_rst_busy",  Busy,            0);
      check("mid_rst_done",  done,            0);
      check("mid_rst_addr",  memBus.mem_addr, 0);
      check("mid_rst_rdata", rdata_vec,       0);
      @(negedge clk);
      @(negedge clk);
      rst_n            = 1'b1;
      memBus.mem_ack   = 1'b0;
      expRdata         = '0;
      idle(4, 1'b0);

      // Randomized accesses with random wait states and spacing.
      for (int t = 0; t < 24; t++) begin
         access(1'($urandom), $urandom, {$urandom, $urandom, $urandom, $urandom},
                $urandom_range(0, 3));
         if ($urandom_range(0, 1) == 1) idle($urandom_range(1, 3), 1'($urandom));
      end
      idle(2, 1'b0);

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/vec_mem_sequencer.md
Name: vec_mem_sequencer

Overview:
Multi-cycle vector memory access unit for the Memory stage. It splits one VEC_WIDTH-bit vector load or store into LANES sequential word transactions on a word-wide data-memory port. It drives Busy to the hazard unit so the pipeline stalls until the access completes. It is the producer side of the hazard unit's Busy stall interface.

Parameters:
VEC_WIDTH, 128, vector register width in bits
WORD_WIDTH, 32, memory port data width; VEC_WIDTH must be an integer multiple of it
ADDR_WIDTH, 32, byte address width

Ports:
clk  input  1  system clock, all state updates on rising edge
rst_n  input  1  asynchronous, active-low reset
start  input  1  level request from M stage; held high while the stage is stalled
we  input  1  1 = vector store, 0 = vector load; sampled with start
base_addr  input  ADDR_WIDTH  byte address of lane 0
wdata_vec  input  VEC_WIDTH  store data; sampled with start
mem_req  output  1  word transaction request
mem_we  output  1  word write enable
mem_addr  output  ADDR_WIDTH  word byte address
mem_wdata  output  WORD_WIDTH  word store data
mem_rdata  input  WORD_WIDTH  word load data, valid with mem_ack
mem_ack  input  1  transaction complete
Busy  output  1  stall request to hazard unit
done  output  1  one-cycle completion pulse
rdata_vec  output  VEC_WIDTH  assembled load result, held until next load completes

Behaviour:
- Derived constants: LANES = VEC_WIDTH/WORD_WIDTH (4 by default); BYTE_STRIDE = WORD_WIDTH/8 (4).
- Lane i occupies vector bits [i*WORD_WIDTH +: WORD_WIDTH] at address base + i*BYTE_STRIDE.
- Address arithmetic is modulo 2^ADDR_WIDTH, so wrap-around is silent.
- The low log2(BYTE_STRIDE) bits of base_addr are forced to 0 on capture.
- FSM has three states: IDLE, ACCESS, DONE.
- IDLE:
  - start=1 latches we, the aligned base address and wdata_vec, clears the lane counter, and moves to ACCESS.
  - start=0 stays in IDLE.
- ACCESS:
  - mem_req=1; mem_we, mem_addr and mem_wdata (lane slice of the latched data) are stable until an ack.
  - On mem_ack=1 for a load, mem_rdata is written into lane[counter] of the rdata register.
  - On mem_ack with counter=LANES-1, move to DONE; otherwise increment the counter.
  - Zero-wait ack (same cycle as req) is legal.
- DONE:
  - done=1 and Busy=0 for exactly one cycle; next state is IDLE.
  - start is ignored in DONE, because that is the completing instruction still leaving M.
- Busy = (state==IDLE & start) | (state==ACCESS). It is combinational so the hazard unit stalls in the same cycle the instruction reaches M.
- mem_ack while mem_req=0 is ignored.
- Latency with mem_ack tied high:
  - start at cycle 0; mem_req high in cycles 1..LANES.
  - done at cycle LANES+1.
  - Busy high in cycles 0..LANES.
  - Each wait cycle on mem_ack adds one cycle.
- Stores leave rdata_vec unchanged.
- Changes on the start-side inputs after capture have no effect.
- Reset, asynchronous and at any time including mid-ACCESS:
  - state goes to IDLE; counter and latched data go to 0.
  - mem_req, mem_we, done and Busy (given start=0) go to 0; mem_addr, mem_wdata and rdata_vec go to 0.
  - No partial transaction is resumed.

Decomposition:
- Shared package vec_mem_pkg holds:
  - the state enum (IDLE, ACCESS, DONE);
  - default width constants VEC_WIDTH=128, WORD_WIDTH=32, ADDR_WIDTH=32;
  - the derived LANES and BYTE_STRIDE.
- A single module is sufficient. The FSM, lane counter and data registers are tightly coupled, so no sub-module is split out.

Test Plan:
- Load, ack tied high, base=0x100, memory words 0x11111111/0x22222222/0x33333333/0x44444444 at 0x100..0x10C -> mem_addr sequence 0x100, 0x104, 0x108, 0x10C; done at cycle 5; rdata_vec=0x44444444_33333333_22222222_11111111; Busy high cycles 0..4.
- Store, wdata_vec=0xDEADBEEF_CAFEF00D_01234567_89ABCDEF, base=0x200, ack delayed 2 cycles per word -> mem_wdata 0x89ABCDEF, 0x01234567, 0xCAFEF00D, 0xDEADBEEF, each held stable until ack; done at cycle 13; rdata_vec unchanged.
- Misaligned/wrap: base=0xFFFFFFFE -> addresses 0xFFFFFFFC, 0x00000000, 0x00000004, 0x00000008.
- Back-to-back: start held through DONE, then a new start in IDLE -> exactly two accesses, one done pulse each, no spurious third access.
- Reset asserted after second lane ack -> mem_req, Busy and done drop immediately; after release with start=0 the block stays IDLE and rdata_vec=0.
- Stray mem_ack in IDLE with rdata 0xFFFFFFFF -> rdata_vec unchanged, state stays IDLE.
